// File: rtl/control_unit_pkg.sv
// Shared types and instruction encodings for the control unit.
package cirno_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_HALT,
    CLS_JMP,
    CLS_BEQ,
    CLS_JMPI,
    CLS_BEQI,
    CLS_LD,
    CLS_ST
  } inst_class_t;

  localparam logic [8:0] HALT_INST_DEFAULT = 9'b000000001;
  localparam logic [8:0] JMP_INST          = 9'b000001000;
  localparam logic [8:0] BEQ_INST          = 9'b000000100;
  localparam logic [2:0] JMPI_PFX          = 3'b111;
  localparam logic [4:0] BEQI_PFX          = 5'b01011;
  localparam logic [4:0] LD_PFX            = 5'b01000;
  localparam logic [4:0] ST_PFX            = 5'b01001;

endpackage

// File: rtl/control_unit_if.sv
// Fetch-unit and data-memory handshake signals seen by the control unit.
interface control_unit_if;
  logic [8:0] inst;
  logic       fetch_unit_en;
  logic       branch;
  logic       branchi;
  logic       jump;
  logic [5:0] immediate;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;

  modport master (
    input  inst, mem_ack,
    output fetch_unit_en, branch, branchi, jump, immediate, mem_req, mem_we
  );

  modport slave (
    output inst, mem_ack,
    input  fetch_unit_en, branch, branchi, jump, immediate, mem_req, mem_we
  );
endinterface

// File: rtl/control_unit_decoder.sv
// Combinational instruction classifier and branch-offset extractor.
module inst_decoder
  import cirno_pkg::*;
#(
  parameter logic [8:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic [8:0]  inst,
  output inst_class_t cls,
  output logic [5:0]  immediate
);

  // Priority order matters: exact encodings first, then prefix matches.
  always_comb begin
    cls       = CLS_ALU;
    immediate = 6'd0;
    if (inst == HALT_INST) begin
      cls = CLS_HALT;
    end else if (inst == JMP_INST) begin
      cls = CLS_JMP;
    end else if (inst == BEQ_INST) begin
      cls = CLS_BEQ;
    end else if (inst[8:6] == JMPI_PFX) begin
      cls       = CLS_JMPI;
      immediate = inst[5:0];
    end else if (inst[8:4] == BEQI_PFX) begin
      cls       = CLS_BEQI;
      immediate = {2'b00, inst[3:0]};
    end else if (inst[8:4] == LD_PFX) begin
      cls = CLS_LD;
    end else if (inst[8:4] == ST_PFX) begin
      cls = CLS_ST;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Sequencing FSM for the processor: drives fetch, branch, ALU commit and
// data-memory handshake, and keeps saturating performance counters.
module control_unit
  import cirno_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [8:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 start,
  input  logic                 eq_flag,
  control_unit_if.master       bus,
  output logic                 alu_en,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     inst_count
);

  state_t      state;
  inst_class_t cls;
  logic [5:0]  dec_imm;

  logic       fetch_en;
  logic       branch_c;
  logic       branchi_c;
  logic       jump_c;
  logic [5:0] imm_c;
  logic       mem_req_c;
  logic       mem_we_c;

  inst_decoder #(.HALT_INST(HALT_INST)) u_dec (
    .inst      (bus.inst),
    .cls       (cls),
    .immediate (dec_imm)
  );

  // Control outputs decoded from current state and instruction class.
  always_comb begin
    fetch_en  = 1'b0;
    branch_c  = 1'b0;
    branchi_c = 1'b0;
    jump_c    = 1'b0;
    imm_c     = 6'd0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    alu_en    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_en   = 1'b1;
            fetch_en = 1'b1;
          end
          CLS_JMP: begin
            branch_c = 1'b1;
            fetch_en = 1'b1;
          end
          CLS_BEQ: begin
            branch_c = eq_flag;
            fetch_en = 1'b1;
          end
          CLS_JMPI: begin
            branchi_c = 1'b1;
            jump_c    = 1'b1;
            imm_c     = dec_imm;
            fetch_en  = 1'b1;
          end
          CLS_BEQI: begin
            branchi_c = eq_flag;
            imm_c     = dec_imm;
            fetch_en  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (cls == CLS_ST);
        fetch_en  = bus.mem_ack;
      end
      ST_HALT: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.fetch_unit_en = fetch_en;
  assign bus.branch        = branch_c;
  assign bus.branchi       = branchi_c;
  assign bus.jump          = jump_c;
  assign bus.immediate     = imm_c;
  assign bus.mem_req       = mem_req_c;
  assign bus.mem_we        = mem_we_c;

  // State transitions and saturating counters; init overrides everything.
  always_ff @(posedge clk) begin
    if (init) begin
      state       <= ST_IDLE;
      cycle_count <= '0;
      inst_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_EXEC;
        ST_EXEC: begin
          if (cls == CLS_LD || cls == CLS_ST) state <= ST_MEM;
          else if (cls == CLS_HALT)          state <= ST_HALT;
        end
        ST_MEM:  if (bus.mem_ack) state <= ST_EXEC;
        default: state <= ST_HALT;
      endcase
      if ((state == ST_EXEC || state == ST_MEM) && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (fetch_en && inst_count != '1)
        inst_count <= inst_count + 1'b1;
    end
  end

endmodule
